t03_vga_timing: RTL
===================

Name: t03_vga_timing

Overview:
- Raster timing generator that produces the Hcnt/Vcnt pixel coordinates consumed by the sprite and text display stages, such as the player display blocks.
- Also generates the hsync and vsync pins, an active-video qualifier, and frame/vblank strobes for game-logic handshakes.
- Runs from the system clock with an internal pixel-rate divider.
- Sits at the head of the video pipeline. Every display stage and the colour compositor key off its outputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=1)
- SYNC_POL, 0, asserted sync level (0 = active-low sync pulses)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  timing enable; low holds the raster at origin
- Hcnt  out  11  current pixel column, 0..H_TOTAL-1
- Vcnt  out  11  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync pin
- vsync  out  1  vertical sync pin
- active  out  1  high when Hcnt<H_ACTIVE and Vcnt<V_ACTIVE
- pix_tick  out  1  one-clk strobe; Hcnt advances on the next edge
- frame_start  out  1  one-clk pulse when the raster wraps to (0,0)
- vblank_start  out  1  one-clk pulse when Vcnt becomes V_ACTIVE
- frame_cnt  out  8  frames completed since reset, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). All compares are unsigned, 11-bit.
- Reset (rst=0, asynchronous): div=0, Hcnt=0, Vcnt=0, pix_tick=0, frame_start=0, vblank_start=0, frame_cnt=0, active=0, hsync=vsync=~SYNC_POL (idle).
- Divider:
  - div counts 0..CLK_DIV-1 while en=1.
  - pix_tick is registered and is high during the clk cycle when div==CLK_DIV-1.
  - With CLK_DIV=1, pix_tick is constantly high while en=1.
- Counters:
  - Hcnt increments on each clk edge where pix_tick=1.
  - At H_TOTAL-1, Hcnt wraps to 0 and Vcnt increments.
  - At V_TOTAL-1, Vcnt wraps to 0.
  - Hcnt and Vcnt never take values >= their totals.
- Decoded outputs (active, hsync, vsync):
  - Registered, computed from the next-state counters, so they are cycle-aligned with the Hcnt/Vcnt values they describe (zero relative latency).
  - hsync=SYNC_POL when H_ACTIVE+H_FP <= Hcnt < H_ACTIVE+H_FP+H_SYNC. Default: Hcnt 656..751.
  - vsync=SYNC_POL when V_ACTIVE+V_FP <= Vcnt < V_ACTIVE+V_FP+V_SYNC. Default: Vcnt 490..491.
  - Otherwise hsync/vsync are ~SYNC_POL.
- Strobes:
  - frame_start is high for exactly one clk, aligned with the first clk at which (Hcnt,Vcnt)=(0,0) after a wrap from (H_TOTAL-1,V_TOTAL-1).
  - frame_cnt increments in that same update and wraps 255->0.
  - vblank_start is high for one clk, aligned with the first clk of (Hcnt=0, Vcnt=V_ACTIVE).
  - The first frame after reset does not produce frame_start; it fires only on wrap.
- en=0 (synchronous):
  - Next edge: div, Hcnt, Vcnt clear to 0; pix_tick and strobes are 0; active=0; syncs idle.
  - frame_cnt holds its value.
  - On en returning to 1, the raster restarts from (0,0). The first pix_tick occurs CLK_DIV clks later.
- Reset mid-frame returns all state to reset values immediately. There is no partial-frame recovery.
- Frame length: H_TOTAL*V_TOTAL*CLK_DIV clks (default 840000).

Test Plan:
- Reset/idle: hold rst=0, en=1 -> Hcnt=0, Vcnt=0, hsync=vsync=1, active=0, frame_cnt=0. After release, first clk shows active=1 and Hcnt=0.
- Line timing, defaults: run one line -> pix_tick every 2 clks; hsync=0 exactly for Hcnt 656..751 (96 pixels = 192 clks); active=0 from Hcnt=640; Hcnt 799->0 with Vcnt 0->1.
- Frame timing, small overrides (H 8/2/2/2, V 6/1/1/1, CLK_DIV=1):
  - H_TOTAL=14, V_TOTAL=9.
  - vsync=0 only on Vcnt=7.
  - vblank_start at (0,6).
  - frame_start every 126 clks.
  - frame_cnt 0->1->2.
- Enable drop: en=0 at (Hcnt=300, Vcnt=200) -> next clk Hcnt=Vcnt=0, syncs idle, frame_cnt unchanged. en=1 -> first Hcnt increment after CLK_DIV clks.
- Wrap/overflow: small config run for 256 frames -> frame_cnt 255->0 on the 256th frame_start; Hcnt/Vcnt never exceed 13/8.
- Async reset mid-line: assert rst between clk edges at Hcnt=5 -> outputs reach reset values before the next edge. After release, the sequence restarts at (0,0).

Source files
------------

// File: rtl/t03_vga_timing.sv
// Raster timing generator: pixel-rate divider, Hcnt/Vcnt raster counters,
// sync/active decode and frame/vblank strobes for the video pipeline.
module t03_vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] Hcnt,
  output logic [10:0] Vcnt,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] V_VLAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic             pix_tick_q, pix_tick_d;
  logic             active_q, active_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             fs_q, fs_d, vb_q, vb_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  always_comb begin
    div_d       = '0;
    pix_tick_d  = 1'b0;
    hcnt_d      = '0;
    vcnt_d      = '0;
    fs_d        = 1'b0;
    vb_d        = 1'b0;
    frame_cnt_d = frame_cnt_q;
    active_d    = 1'b0;
    hsync_d     = ~SYNC_POL;
    vsync_d     = ~SYNC_POL;
    if (en) begin
      div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      // Registered tick is high while div holds its last value.
      pix_tick_d = (div_d == DIV_LAST);
      hcnt_d     = hcnt_q;
      vcnt_d     = vcnt_q;
      if (pix_tick_q) begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          vb_d   = (vcnt_q == V_VLAST);
          if (vcnt_q == V_LAST) begin
            vcnt_d      = '0;
            fs_d        = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            vcnt_d = vcnt_q + 11'd1;
          end
        end else begin
          hcnt_d = hcnt_q + 11'd1;
        end
      end
      // Decode from next-state counters so outputs align with Hcnt/Vcnt.
      active_d = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
      hsync_d  = ((hcnt_d >= HS_BEG) && (hcnt_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d  = ((vcnt_d >= VS_BEG) && (vcnt_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      pix_tick_q  <= 1'b0;
      active_q    <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      fs_q        <= 1'b0;
      vb_q        <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      div_q       <= div_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      pix_tick_q  <= pix_tick_d;
      active_q    <= active_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      fs_q        <= fs_d;
      vb_q        <= vb_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign Hcnt         = hcnt_q;
  assign Vcnt         = vcnt_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign active       = active_q;
  assign pix_tick     = pix_tick_q;
  assign frame_start  = fs_q;
  assign vblank_start = vb_q;
  assign frame_cnt    = frame_cnt_q;

endmodule
